// File: rtl/vec_pkg.sv
// Shared definitions for the vector execute unit: opcodes, SEW codes, FSM states, element helpers.
package vec_pkg;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned VD_W   = 5;
    localparam int unsigned SEW_W  = 2;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned EC_W   = 4;
    localparam int unsigned BITS_W = 7;
    localparam int unsigned SH_W   = 6;
    localparam int unsigned MAX_EL = 8;

    localparam logic [OP_W-1:0] OP_ADD = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB = 4'd1;
    localparam logic [OP_W-1:0] OP_AND = 4'd2;
    localparam logic [OP_W-1:0] OP_OR  = 4'd3;
    localparam logic [OP_W-1:0] OP_XOR = 4'd4;
    localparam logic [OP_W-1:0] OP_SLL = 4'd5;
    localparam logic [OP_W-1:0] OP_SRL = 4'd6;
    localparam logic [OP_W-1:0] OP_SRA = 4'd7;
    localparam logic [OP_W-1:0] OP_MIN = 4'd8;
    localparam logic [OP_W-1:0] OP_MUL = 4'd9;

    localparam logic [SEW_W-1:0] SEW_8  = 2'b00;
    localparam logic [SEW_W-1:0] SEW_16 = 2'b01;
    localparam logic [SEW_W-1:0] SEW_32 = 2'b10;
    localparam logic [SEW_W-1:0] SEW_64 = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    // Operands and destination captured for the iterative multiply
    typedef struct packed {
        logic [VD_W-1:0]   vd;
        logic [SEW_W-1:0]  sew;
        logic [DATA_W-1:0] opa;
        logic [DATA_W-1:0] opb;
    } mul_ctx_t;

    function automatic logic [EC_W-1:0] elem_count(input logic [SEW_W-1:0] sew);
        case (sew)
            SEW_8:   return 4'd8;
            SEW_16:  return 4'd4;
            SEW_32:  return 4'd2;
            default: return 4'd1;
        endcase
    endfunction

    function automatic logic [BITS_W-1:0] sew_bits(input logic [SEW_W-1:0] sew);
        case (sew)
            SEW_8:   return 7'd8;
            SEW_16:  return 7'd16;
            SEW_32:  return 7'd32;
            default: return 7'd64;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] sew_mask(input logic [SEW_W-1:0] sew);
        case (sew)
            SEW_8:   return 64'h0000_0000_0000_00FF;
            SEW_16:  return 64'h0000_0000_0000_FFFF;
            SEW_32:  return 64'h0000_0000_FFFF_FFFF;
            default: return 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/vec_exec_unit_alu.sv
// Combinational SIMD ALU for ADD..MIN; each lane is processed left-aligned so wrap and sign come for free.
module vec_lane_alu
    import vec_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [OP_W-1:0]   op,
    input  logic [SEW_W-1:0]  sew,
    output logic [DATA_W-1:0] result_c
);

    // One lane: operands arrive right-aligned, are moved to the MSB end, operated on, and moved back
    function automatic logic [DATA_W-1:0] lane_op(
        input logic [DATA_W-1:0] ea,
        input logic [DATA_W-1:0] eb,
        input logic [OP_W-1:0]   lop,
        input logic [BITS_W-1:0] w
    );
        logic [BITS_W-1:0] pad;
        logic [DATA_W-1:0] xa;
        logic [DATA_W-1:0] xb;
        logic [DATA_W-1:0] hi;
        logic [DATA_W-1:0] r;
        logic [SH_W-1:0]   sh;
        pad = BITS_W'(DATA_W) - w;
        xa  = ea << pad;
        xb  = eb << pad;
        hi  = {DATA_W{1'b1}} << pad;
        sh  = SH_W'(eb) & SH_W'(w - 7'd1);
        case (lop)
            OP_ADD:  r = xa + xb;
            OP_SUB:  r = xa - xb;
            OP_AND:  r = xa & xb;
            OP_OR:   r = xa | xb;
            OP_XOR:  r = xa ^ xb;
            OP_SLL:  r = xa << sh;
            OP_SRL:  r = (xa >> sh) & hi;
            OP_SRA:  r = DATA_W'($signed(xa) >>> sh) & hi;
            OP_MIN:  r = ($signed(xa) < $signed(xb)) ? xa : xb;
            default: r = '0;
        endcase
        return r >> pad;
    endfunction

    logic [BITS_W-1:0] w;
    logic [EC_W-1:0]   n;
    logic [DATA_W-1:0] mask;
    logic [SH_W-1:0]   off;

    // Apply the lane op to every active element and pack the results
    always_comb begin
        w        = sew_bits(sew);
        n        = elem_count(sew);
        mask     = sew_mask(sew);
        off      = '0;
        result_c = '0;
        for (int i = 0; i < int'(MAX_EL); i++) begin
            if (EC_W'(i) < n) begin
                off      = SH_W'(BITS_W'(i) * w);
                result_c = result_c | (lane_op((a >> off) & mask, (b >> off) & mask, op, w) << off);
            end
        end
    end

endmodule

// File: rtl/vec_exec_unit.sv
// SIMD execute stage: single-cycle lane ops, iterative one-element-per-cycle VMUL, registered writeback.
module vec_exec_unit
    import vec_pkg::*;
#(
    parameter int unsigned VLEN = DATA_W,
    parameter int unsigned OPW  = OP_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OPW-1:0]    in_op,
    input  logic [SEW_W-1:0]  in_sew,
    input  logic [VD_W-1:0]   in_vd,
    input  logic [VLEN-1:0]   in_opa,
    input  logic [VLEN-1:0]   in_opb,
    output logic              wb_wen,
    output logic [VD_W-1:0]   wb_vd,
    output logic [VLEN-1:0]   wb_wdata,
    output logic              pend_valid,
    output logic [VD_W-1:0]   pend_vd,
    output logic              busy,
    output logic              illegal_op
);

    state_t            state;
    state_t            next_state;
    mul_ctx_t          ctx;
    logic [CNT_W-1:0]  cnt;
    logic [VLEN-1:0]   acc;
    logic [VLEN-1:0]   acc_next;
    logic [VLEN-1:0]   alu_res;

    logic              accept;
    logic              mul_start;
    logic              mul_last;
    logic              alu_wr;
    logic              bad_op;
    logic              wb_fire;
    logic [VD_W-1:0]   wb_vd_nxt;
    logic [VLEN-1:0]   wb_data_nxt;

    logic [BITS_W-1:0] m_w;
    logic [SH_W-1:0]   m_off;
    logic [VLEN-1:0]   m_mask;
    logic [VLEN-1:0]   m_ea;
    logic [VLEN-1:0]   m_eb;
    logic [VLEN-1:0]   m_prod;

    vec_lane_alu u_alu (
        .a        (in_opa),
        .b        (in_opb),
        .op       (in_op),
        .sew      (in_sew),
        .result_c (alu_res)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    // Next state: enter MUL on an accepted VMUL, leave after the last element
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (accept && (in_op == OP_MUL)) next_state = ST_MUL;
            ST_MUL:  if (mul_last) next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Control decode and writeback selection
    always_comb begin
        accept      = in_valid && in_ready;
        mul_start   = 1'b0;
        mul_last    = 1'b0;
        alu_wr      = 1'b0;
        bad_op      = 1'b0;
        case (state)
            ST_IDLE: begin
                mul_start = accept && (in_op == OP_MUL);
                alu_wr    = accept && (in_op <  OP_MUL);
                bad_op    = accept && (in_op >  OP_MUL);
            end
            ST_MUL:  mul_last = ({1'b0, cnt} == (elem_count(ctx.sew) - 4'd1));
            default: ;
        endcase
        wb_fire     = (alu_wr && (in_vd != '0)) || (mul_last && (ctx.vd != '0));
        wb_vd_nxt   = mul_last ? ctx.vd : in_vd;
        wb_data_nxt = mul_last ? acc_next : alu_res;
    end

    // Shared element multiplier: picks element cnt, keeps the low SEW bits of the product
    always_comb begin
        m_w      = sew_bits(ctx.sew);
        m_mask   = sew_mask(ctx.sew);
        m_off    = SH_W'(BITS_W'(cnt) * m_w);
        m_ea     = (ctx.opa >> m_off) & m_mask;
        m_eb     = (ctx.opb >> m_off) & m_mask;
        m_prod   = m_ea * m_eb;
        acc_next = acc | ((m_prod & m_mask) << m_off);
    end

    // Registered outputs, multiply context and accumulator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready   <= 1'b0;
            busy       <= 1'b0;
            illegal_op <= 1'b0;
            wb_wen     <= 1'b0;
            wb_vd      <= '0;
            wb_wdata   <= '0;
            pend_valid <= 1'b0;
            pend_vd    <= '0;
            ctx        <= '0;
            cnt        <= '0;
            acc        <= '0;
        end else begin
            in_ready   <= (next_state == ST_IDLE);
            busy       <= (next_state == ST_MUL);
            illegal_op <= bad_op;
            wb_wen     <= wb_fire;
            pend_valid <= (next_state == ST_MUL) || wb_fire;
            if (mul_start) begin
                ctx     <= '{vd: in_vd, sew: in_sew, opa: in_opa, opb: in_opb};
                cnt     <= '0;
                acc     <= '0;
                pend_vd <= in_vd;
            end else if (state == ST_MUL) begin
                cnt <= mul_last ? '0 : cnt + CNT_W'(1);
                acc <= acc_next;
            end
            if (wb_fire) begin
                wb_vd    <= wb_vd_nxt;
                wb_wdata <= wb_data_nxt;
                pend_vd  <= wb_vd_nxt;
            end
        end
    end

endmodule

// File: tb/tb_vec_exec_unit.sv
// Self-checking bench for vec_exec_unit with a per-element arithmetic reference model.
module tb_vec_exec_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_op = '0;
    logic [1:0]  in_sew = '0;
    logic [4:0]  in_vd = '0;
    logic [63:0] in_opa = '0;
    logic [63:0] in_opb = '0;
    logic        wb_wen;
    logic [4:0]  wb_vd;
    logic [63:0] wb_wdata;
    logic        pend_valid;
    logic [4:0]  pend_vd;
    logic        busy;
    logic        illegal_op;

    int errors = 0;
    int checks = 0;

    vec_exec_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_sew     (in_sew),
        .in_vd      (in_vd),
        .in_opa     (in_opa),
        .in_opb     (in_opb),
        .wb_wen     (wb_wen),
        .wb_vd      (wb_vd),
        .wb_wdata   (wb_wdata),
        .pend_valid (pend_valid),
        .pend_vd    (pend_vd),
        .busy       (busy),
        .illegal_op (illegal_op)
    );

    always #5 clk = ~clk;

    // Reference: element-by-element arithmetic with explicit sign extension
    function automatic logic [63:0] model(input logic [3:0] op, input logic [1:0] sew,
                                          input logic [63:0] a, input logic [63:0] b);
        int unsigned w = 8 << sew;
        int unsigned n = 64 / w;
        logic [63:0] mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        logic [63:0] res = '0;
        for (int i = 0; i < int'(n); i++) begin
            logic [63:0] ea, eb, sa, sb, r;
            int unsigned sh;
            ea = (a >> (i * w)) & mask;
            eb = (b >> (i * w)) & mask;
            sa = ea[w-1] ? (ea | ~mask) : ea;
            sb = eb[w-1] ? (eb | ~mask) : eb;
            sh = int'(eb % 64'(w));
            case (op)
                4'd0: r = ea + eb;
                4'd1: r = ea - eb;
                4'd2: r = ea & eb;
                4'd3: r = ea | eb;
                4'd4: r = ea ^ eb;
                4'd5: r = ea << sh;
                4'd6: r = ea >> sh;
                4'd7: r = 64'($signed(sa) >>> sh);
                4'd8: r = ($signed(sa) < $signed(sb)) ? ea : eb;
                4'd9: r = ea * eb;
                default: r = '0;
            endcase
            res = res | ((r & mask) << (i * w));
        end
        return res;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [1:0] sew, input logic [4:0] vd,
                         input logic [63:0] a, input logic [63:0] b);
        in_valid = 1'b1;
        in_op    = op;
        in_sew   = sew;
        in_vd    = vd;
        in_opa   = a;
        in_opb   = b;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        drive(4'd0, 2'd0, 5'd3, rnd64(), rnd64());
        repeat (3) tick();
        checks++;
        if ({in_ready, wb_wen, wb_vd, wb_wdata, pend_valid, pend_vd, busy, illegal_op} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=0",
                     {in_ready, wb_wen, wb_vd, wb_wdata, pend_valid, pend_vd, busy, illegal_op});
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_edge got=%b exp=0", in_ready);
        end
        tick();
        checks++;
        if (in_ready !== 1'b1 || wb_wen !== 1'b0) begin
            errors++;
            $display("FAIL ready_after_edge got=%b/%b exp=1/0", in_ready, wb_wen);
        end
    endtask

    task automatic test_directed();
        logic [3:0]  t_op  [3] = '{4'd0, 4'd1, 4'd7};
        logic [1:0]  t_sew [3] = '{2'd0, 2'd1, 2'd2};
        logic [63:0] t_a   [3] = '{64'h0000_0000_0000_00FF, 64'h0, 64'h8000_0000_0000_0010};
        logic [63:0] t_b   [3] = '{64'h0101_0101_0101_0101, 64'h0001_0001_0001_0001, 64'h0000_001F_0000_0004};
        logic [63:0] t_exp [3] = '{64'h0101_0101_0101_0100, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_0000_0001};
        for (int i = 0; i < 3; i++) begin
            drive(t_op[i], t_sew[i], 5'd3, t_a[i], t_b[i]);
            tick();
            in_valid = 1'b0;
            checks++;
            if (wb_wen !== 1'b1 || wb_vd !== 5'd3 || wb_wdata !== t_exp[i] ||
                pend_valid !== 1'b1 || pend_vd !== 5'd3) begin
                errors++;
                $display("FAIL directed_%0d got wen=%b vd=%0d data=%h pend=%b/%0d exp wen=1 vd=3 data=%h pend=1/3",
                         i, wb_wen, wb_vd, wb_wdata, pend_valid, pend_vd, t_exp[i]);
            end
            tick();
            checks++;
            if (wb_wen !== 1'b0 || pend_valid !== 1'b0 || wb_wdata !== t_exp[i]) begin
                errors++;
                $display("FAIL directed_idle_%0d got wen=%b pend=%b data=%h exp 0/0/%h",
                         i, wb_wen, pend_valid, wb_wdata, t_exp[i]);
            end
        end
    endtask

    task automatic test_random_alu();
        for (int i = 0; i < 40; i++) begin
            logic [3:0]  op  = 4'($urandom_range(8, 0));
            logic [1:0]  sew = 2'($urandom_range(3, 0));
            logic [4:0]  vd  = 5'($urandom_range(31, 1));
            logic [63:0] a   = rnd64();
            logic [63:0] b   = rnd64();
            logic [63:0] exp;
            if (i % 4 == 0) b = b & 64'h0707_0707_0707_0707;
            exp = model(op, sew, a, b);
            drive(op, sew, vd, a, b);
            tick();
            checks++;
            if (wb_wen !== 1'b1 || wb_vd !== vd || wb_wdata !== exp) begin
                errors++;
                $display("FAIL rand_alu op=%0d sew=%0d got wen=%b vd=%0d data=%h exp wen=1 vd=%0d data=%h",
                         op, sew, wb_wen, wb_vd, wb_wdata, vd, exp);
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_mul();
        for (int k = 0; k < 6; k++) begin
            logic [1:0]  sew = (k == 0) ? 2'd0 : (k == 1) ? 2'd3 : 2'($urandom_range(3, 0));
            logic [4:0]  vd  = 5'($urandom_range(31, 1));
            logic [63:0] a   = (k == 0) ? 64'h0102_0304_0506_0708 : rnd64();
            logic [63:0] b   = (k == 0) ? 64'h0202_0202_0202_0202 : rnd64();
            logic [63:0] exp = (k == 0) ? 64'h0204_0608_0A0C_0E10 : model(4'd9, sew, a, b);
            int          e   = 8 >> sew;
            int          low = 0;
            int          bad = 0;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL mul_ready_before got=%b exp=1", in_ready);
            end
            drive(4'd9, sew, vd, a, b);
            tick();
            in_valid = 1'b0;
            while (wb_wen !== 1'b1 && low < 20) begin
                if (in_ready !== 1'b0 || busy !== 1'b1 || pend_valid !== 1'b1 || pend_vd !== vd) bad++;
                low++;
                tick();
            end
            checks++;
            if (low != e || bad != 0) begin
                errors++;
                $display("FAIL mul_stall sew=%0d got cycles=%0d bad=%0d exp cycles=%0d bad=0", sew, low, bad, e);
            end
            checks++;
            if (wb_wen !== 1'b1 || wb_vd !== vd || wb_wdata !== exp || in_ready !== 1'b1 ||
                busy !== 1'b0 || pend_valid !== 1'b1) begin
                errors++;
                $display("FAIL mul_result sew=%0d got wen=%b vd=%0d data=%h rdy=%b busy=%b pend=%b exp 1/%0d/%h/1/0/1",
                         sew, wb_wen, wb_vd, wb_wdata, in_ready, busy, pend_valid, vd, exp);
            end
            tick();
            checks++;
            if (wb_wen !== 1'b0 || pend_valid !== 1'b0) begin
                errors++;
                $display("FAIL mul_after got wen=%b pend=%b exp 0/0", wb_wen, pend_valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  ops [4] = '{4'd0, 4'd4, 4'd9, 4'd2};
        logic [1:0]  sew [4];
        logic [4:0]  vd  [4];
        logic [63:0] a   [4];
        logic [63:0] b   [4];
        logic [63:0] exp_q [$];
        logic [4:0]  vd_q  [$];
        int          wbcyc [4] = '{0, 0, 0, 0};
        int          nwb = 0;
        int          idx = 0;
        int          e;
        for (int i = 0; i < 4; i++) begin
            sew[i] = 2'($urandom_range(3, 0));
            vd[i]  = 5'($urandom_range(31, 1));
            a[i]   = rnd64();
            b[i]   = rnd64();
        end
        e = 8 >> sew[2];
        drive(ops[0], sew[0], vd[0], a[0], b[0]);
        for (int c = 0; c < 40; c++) begin
            logic acc;
            acc = in_ready && in_valid;
            tick();
            if (acc) begin
                exp_q.push_back(model(ops[idx], sew[idx], a[idx], b[idx]));
                vd_q.push_back(vd[idx]);
                idx++;
                if (idx < 4) drive(ops[idx], sew[idx], vd[idx], a[idx], b[idx]);
                else         in_valid = 1'b0;
            end
            if (wb_wen === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_unexpected_wb got vd=%0d data=%h exp none", wb_vd, wb_wdata);
                end else begin
                    if (wb_vd !== vd_q[0] || wb_wdata !== exp_q[0]) begin
                        errors++;
                        $display("FAIL b2b_wb_%0d got vd=%0d data=%h exp vd=%0d data=%h",
                                 nwb, wb_vd, wb_wdata, vd_q[0], exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                    void'(vd_q.pop_front());
                end
                if (nwb < 4) wbcyc[nwb] = c;
                nwb++;
            end
        end
        in_valid = 1'b0;
        checks++;
        if (nwb != 4 || wbcyc[1] - wbcyc[0] != 1 || wbcyc[2] - wbcyc[1] != e + 1 ||
            wbcyc[3] - wbcyc[2] != 1) begin
            errors++;
            $display("FAIL b2b_timing got n=%0d cyc=%0d,%0d,%0d,%0d exp n=4 deltas 1,%0d,1",
                     nwb, wbcyc[0], wbcyc[1], wbcyc[2], wbcyc[3], e + 1);
        end
    endtask

    task automatic test_vd0_illegal();
        logic [4:0]  prev_vd   = wb_vd;
        logic [63:0] prev_data = wb_wdata;
        drive(4'd0, 2'($urandom_range(3, 0)), 5'd0, rnd64(), rnd64());
        tick();
        in_valid = 1'b0;
        checks++;
        if (wb_wen !== 1'b0 || pend_valid !== 1'b0 || wb_vd !== prev_vd || wb_wdata !== prev_data ||
            illegal_op !== 1'b0) begin
            errors++;
            $display("FAIL vd0_add got wen=%b pend=%b vd=%0d data=%h ill=%b exp 0/0/%0d/%h/0",
                     wb_wen, pend_valid, wb_vd, wb_wdata, illegal_op, prev_vd, prev_data);
        end
        for (int op = 10; op < 16; op++) begin
            drive(4'(op), 2'($urandom_range(3, 0)), 5'd5, rnd64(), rnd64());
            tick();
            in_valid = 1'b0;
            checks++;
            if (illegal_op !== 1'b1 || wb_wen !== 1'b0 || pend_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL illegal_%0d got ill=%b wen=%b pend=%b rdy=%b exp 1/0/0/1",
                         op, illegal_op, wb_wen, pend_valid, in_ready);
            end
            tick();
            checks++;
            if (illegal_op !== 1'b0) begin
                errors++;
                $display("FAIL illegal_pulse_%0d got=%b exp=0", op, illegal_op);
            end
        end
    endtask

    task automatic test_reset_mid_mul();
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          seen = 0;
        int          wait_c = 0;
        drive(4'd9, 2'd0, 5'd7, rnd64(), rnd64());
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || wb_wen !== 1'b0 || pend_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_in_reset got busy=%b wen=%b pend=%b rdy=%b exp 0/0/0/0",
                     busy, wb_wen, pend_valid, in_ready);
        end
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (wb_wen !== 1'b0 || pend_valid !== 1'b0 || busy !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL abort_after_release got bad_cycles=%0d exp=0", seen);
        end
        a   = rnd64();
        b   = rnd64();
        exp = model(4'd9, 2'd0, a, b);
        drive(4'd9, 2'd0, 5'd7, a, b);
        tick();
        in_valid = 1'b0;
        while (wb_wen !== 1'b1 && wait_c < 20) begin
            wait_c++;
            tick();
        end
        checks++;
        if (wb_wen !== 1'b1 || wb_vd !== 5'd7 || wb_wdata !== exp || wait_c != 8) begin
            errors++;
            $display("FAIL reissue_mul got wen=%b vd=%0d data=%h wait=%0d exp 1/7/%h/8",
                     wb_wen, wb_vd, wb_wdata, wait_c, exp);
        end
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_random_alu();
        test_mul();
        test_back_to_back();
        test_vd0_illegal();
        test_reset_mid_mul();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
